// File: rtl/hs_ram_arbiter.sv
// Hands the game work RAM port to the hiscore engine once the CPU is paused and settled,
// and gives it back to the CPU (after a one-cycle release guard) when the engine is done.
module hs_ram_arbiter #(
  parameter int AW     = 11,
  parameter int DW     = 8,
  parameter int SETTLE = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_dout,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write_enable,
  input  logic          hs_read_intent,
  input  logic          hs_write_intent,
  output logic [DW-1:0] hs_data_out,
  input  logic          paused,
  output logic          cpu_hold,
  output logic          hs_grant,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic [3:0] settle_cnt_next;
  logic       hold_next;
  logic       grant_next;
  logic       grant_d;
  logic       intent;

  assign intent = hs_read_intent | hs_write_intent;

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    case (state)
      ST_IDLE: begin
        if (intent) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!intent) begin
          state_next = ST_IDLE;
        end else if (paused) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!intent) begin
          state_next = ST_IDLE;
        end else if (!paused) begin
          state_next = ST_WAIT;
        end else if (settle_cnt == 4'd0) begin
          state_next = ST_GRANT;
        end else begin
          settle_cnt_next = settle_cnt - 4'd1;
        end
      end
      ST_GRANT: begin
        if (!intent) begin
          state_next = ST_RELEASE;
        end else if (!paused) begin
          state_next = ST_WAIT;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  assign hold_next  = (state_next != ST_IDLE);
  assign grant_next = (state_next == ST_GRANT);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      cpu_hold   <= 1'b0;
      hs_grant   <= 1'b0;
      grant_d    <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      cpu_hold   <= hold_next;
      hs_grant   <= grant_next;
      grant_d    <= hs_grant;
    end
  end

  // RAM read data belongs to the engine when its address went out on the previous cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_data_out <= '0;
    end else if (grant_d) begin
      hs_data_out <= ram_dout;
    end
  end

  assign ram_addr = hs_grant ? hs_address      : cpu_addr;
  assign ram_din  = hs_grant ? hs_data_in      : cpu_din;
  assign ram_we   = hs_grant ? hs_write_enable : cpu_we;
  assign cpu_dout = ram_dout;

endmodule
